axi_master_mmap_lite: RTL and testbench



---
 rtl/axi_master_mmap_lite.sv | 185 ++++++++++++++++++
 tb/tb_axi_master_mmap_lite.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_mmap_lite.sv
// AXI4-Lite master: turns single-beat register commands into AXI4-Lite
// transactions, one outstanding at a time, with a valid/ready response port.
module axi_master_mmap_lite #(
    parameter int         C_M_AXI_ADDR_WIDTH = 4,
    parameter int         C_M_AXI_DATA_WIDTH = 32,
    parameter logic [2:0] C_M_AXI_PROT       = 3'b000
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // WRITE | AW and W beats outstanding, each dropped on its own handshake
    // WRESP | both write beats done, waiting for B
    // RADDR | AR beat outstanding
    // RDATA | waiting for R
    // RSP   | response held on rsp_* until consumed
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RSP} state_t;

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    state_t                          state_q;
    logic                            cmd_ready_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]               wstrb_q;
    logic                            awvalid_q;
    logic                            wvalid_q;
    logic                            bready_q;
    logic                            arvalid_q;
    logic                            rready_q;
    logic                            aw_done_q;
    logic                            w_done_q;
    logic                            rsp_valid_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]                      rsp_resp_q;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    logic aw_done_d, w_done_d;

    assign cmd_hs    = cmd_valid & cmd_ready_q;
    assign aw_hs     = awvalid_q & M_AXI_AWREADY;
    assign w_hs      = wvalid_q & M_AXI_WREADY;
    assign b_hs      = bready_q & M_AXI_BVALID;
    assign ar_hs     = arvalid_q & M_AXI_ARREADY;
    assign r_hs      = rready_q & M_AXI_RVALID;
    assign rsp_hs    = rsp_valid_q & rsp_ready;
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q | w_hs;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WRITE;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RADDR;
                        end
                    end
                end
                WRITE: begin
                    // AW and W complete independently; B is only accepted once both are in
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= M_AXI_BRESP;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RDATA;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= M_AXI_RDATA;
                        rsp_resp_q  <= M_AXI_RRESP;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = C_M_AXI_PROT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = C_M_AXI_PROT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_master_mmap_lite.sv
// Bench for axi_master_mmap_lite: acts as command source, AXI4-Lite slave and
// response sink, and checks every output each cycle against a transaction-level model.
module tb_axi_master_mmap_lite;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axi_master_mmap_lite #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_PROT(3'b000)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // One command plus everything the slave/sink will do for it.
    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          aw_dly, w_dly, ar_dly, b_dly, r_dly, rsp_dly;
    } cmd_t;

    cmd_t cmd_q[$];
    cmd_t cur;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit model_valid = 0, busy = 0, resp_done = 0, rst_chk = 0;
    int aw_cnt, w_cnt, ar_cnt;
    int aw_wait, w_wait, ar_wait, b_wait, r_wait, rsp_wait, hold_cnt;
    int acc_cyc, rsp_cyc, done_cnt = 0;
    int last_lat, last_hold;
    logic [31:0] last_awaddr, last_wdata, last_araddr, last_rsp_rdata;
    logic [3:0]  last_wstrb;
    logic [1:0]  last_rsp_resp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(bit wr, logic [3:0] a, logic [31:0] d, logic [3:0] s,
                                logic [1:0] r, logic [31:0] rd, int awd, int wd, int ard,
                                int bd, int rdd, int rspd);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wdata = d; c.wstrb = s; c.resp = r; c.rdata = rd;
        c.aw_dly = awd; c.w_dly = wd; c.ar_dly = ard; c.b_dly = bd; c.r_dly = rdd; c.rsp_dly = rspd;
        return c;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Model + slave + sink, all evaluated at the falling edge.
    initial begin
        bit e_aw, e_w, e_b, e_ar, e_r, both_in;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            cyc++;
            e_aw = busy && cur.wr && aw_cnt == 0;
            e_w  = busy && cur.wr && w_cnt == 0;
            e_b  = busy && cur.wr && aw_cnt == 1 && w_cnt == 1 && !resp_done;
            e_ar = busy && !cur.wr && ar_cnt == 0;
            e_r  = busy && !cur.wr && ar_cnt == 1 && !resp_done;
            if (model_valid) begin
                chk("cmd_ready", cmd_ready, !busy);
                chk("awvalid", awvalid, e_aw);
                chk("wvalid", wvalid, e_w);
                chk("bready", bready, e_b);
                chk("arvalid", arvalid, e_ar);
                chk("rready", rready, e_r);
                chk("rsp_valid", rsp_valid, busy && resp_done);
                if (e_aw) begin
                    chk("awaddr", awaddr, cur.addr);
                    chk("awprot", awprot, 3'b000);
                end
                if (e_w) begin
                    chk("wdata", wdata, cur.wdata);
                    chk("wstrb", wstrb, cur.wstrb);
                end
                if (e_ar) begin
                    chk("araddr", araddr, cur.addr);
                    chk("arprot", arprot, 3'b000);
                end
                if (busy && resp_done) begin
                    chk("rsp_resp", rsp_resp, cur.resp);
                    chk("rsp_rdata", rsp_rdata, cur.wr ? 32'h0 : cur.rdata);
                end
            end
            if (rst_chk) begin
                chk("rst_rsp_rdata", rsp_rdata, 32'h0);
                chk("rst_rsp_resp", rsp_resp, 2'b00);
                chk("rst_awaddr", awaddr, 4'h0);
                chk("rst_araddr", araddr, 4'h0);
                chk("rst_wdata", wdata, 32'h0);
                chk("rst_wstrb", wstrb, 4'h0);
                rst_chk = 0;
            end
            if (rst) begin
                model_valid = 1; busy = 0; resp_done = 0; rst_chk = 1;
                cmd_valid = 0; rsp_ready = 0; awready = 0; wready = 0; arready = 0;
                bvalid = 0; rvalid = 0;
            end else begin
                cmd_valid = (cmd_q.size() > 0);
                if (cmd_valid) begin
                    cmd_write = cmd_q[0].wr;
                    cmd_addr  = cmd_q[0].addr;
                    cmd_wdata = cmd_q[0].wdata;
                    cmd_wstrb = cmd_q[0].wstrb;
                end
                // slave address/data channels: ready after the per-command delay
                awready = awvalid ? (busy && aw_wait >= cur.aw_dly) : 1'($urandom_range(0, 1));
                if (awvalid && !awready) aw_wait++;
                wready = wvalid ? (busy && w_wait >= cur.w_dly) : 1'($urandom_range(0, 1));
                if (wvalid && !wready) w_wait++;
                arready = arvalid ? (busy && ar_wait >= cur.ar_dly) : 1'($urandom_range(0, 1));
                if (arvalid && !arready) ar_wait++;
                both_in = busy && cur.wr && aw_cnt >= 1 && w_cnt >= 1 && !resp_done;
                bvalid = both_in && b_wait >= cur.b_dly;
                bresp  = bvalid ? cur.resp : 2'($urandom_range(0, 3));
                if (both_in && !(bvalid && bready)) b_wait++;
                rvalid = busy && !cur.wr && ar_cnt >= 1 && !resp_done && r_wait >= cur.r_dly;
                rdata  = rvalid ? cur.rdata : $urandom;
                rresp  = rvalid ? cur.resp : 2'($urandom_range(0, 3));
                if (busy && !cur.wr && ar_cnt >= 1 && !resp_done && !(rvalid && rready)) r_wait++;
                if (rsp_valid) begin
                    rsp_ready = busy && rsp_wait >= cur.rsp_dly;
                    if (!rsp_ready) begin rsp_wait++; hold_cnt++; end
                end else begin
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                // what the coming edge commits
                if (awvalid && awready) begin aw_cnt++; last_awaddr = 32'(awaddr); end
                if (wvalid && wready) begin w_cnt++; last_wdata = wdata; last_wstrb = wstrb; end
                if (arvalid && arready) begin ar_cnt++; last_araddr = 32'(araddr); end
                if ((bvalid && bready) || (rvalid && rready)) begin
                    resp_done = 1; rsp_cyc = cyc + 1;
                end
                if (rsp_valid && rsp_ready && busy) begin
                    done_cnt++;
                    last_rsp_rdata = rsp_rdata;
                    last_rsp_resp  = rsp_resp;
                    last_lat  = rsp_cyc - acc_cyc;
                    last_hold = hold_cnt;
                    chk("latency", last_lat, cur.wr ? 3 + imax(cur.aw_dly, cur.w_dly) + cur.b_dly
                                                    : 3 + cur.ar_dly + cur.r_dly);
                    chk("aw_beats", aw_cnt, cur.wr ? 1 : 0);
                    chk("w_beats", w_cnt, cur.wr ? 1 : 0);
                    chk("ar_beats", ar_cnt, cur.wr ? 0 : 1);
                    busy = 0;
                end
                if (cmd_valid && cmd_ready) begin
                    cur = cmd_q.pop_front();
                    busy = 1; resp_done = 0;
                    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                    rsp_wait = 0; hold_cnt = 0;
                    acc_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("completion", done_cnt >= target, 1'b1);
    endtask

    initial begin
        int base;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_awvalid", awvalid, 1'b0);
        @(posedge clk); #1;

        // always-ready write
        cmd_q.push_back(mk(1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 0));
        wait_done(1, 50);
        chk("w1_awaddr", last_awaddr, 32'h4);
        chk("w1_wdata", last_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", last_wstrb, 4'hF);
        chk("w1_latency", last_lat, 3);
        chk("w1_rdata", last_rsp_rdata, 32'h0);
        chk("w1_resp", last_rsp_resp, 2'b00);

        // always-ready read
        cmd_q.push_back(mk(0, 4'h8, 32'h0, 4'h0, 2'b00, 32'h12345678, 0, 0, 0, 0, 0, 0));
        wait_done(2, 50);
        chk("r1_araddr", last_araddr, 32'h8);
        chk("r1_rdata", last_rsp_rdata, 32'h12345678);
        chk("r1_resp", last_rsp_resp, 2'b00);
        chk("r1_latency", last_lat, 3);

        // W three cycles after AW, then the reverse order
        cmd_q.push_back(mk(1, 4'hC, 32'hA5A5_0001, 4'h3, 2'b00, 32'h0, 0, 3, 0, 0, 0, 0));
        wait_done(3, 60);
        chk("w2_latency", last_lat, 6);
        chk("w2_wdata", last_wdata, 32'hA5A5_0001);
        cmd_q.push_back(mk(1, 4'h2, 32'h5A5A_0002, 4'hC, 2'b01, 32'h0, 3, 0, 0, 1, 0, 0));
        wait_done(4, 60);
        chk("w3_latency", last_lat, 7);
        chk("w3_awaddr", last_awaddr, 32'h2);
        chk("w3_resp", last_rsp_resp, 2'b01);

        // SLVERR read with response held off for 5 cycles
        cmd_q.push_back(mk(0, 4'hA, 32'h0, 4'h0, 2'b10, 32'hCAFEF00D, 0, 0, 0, 0, 0, 5));
        wait_done(5, 60);
        chk("r2_resp", last_rsp_resp, 2'b10);
        chk("r2_rdata", last_rsp_rdata, 32'hCAFEF00D);
        chk("r2_hold", last_hold, 5);

        // reset while AWVALID is pending
        base = done_cnt;
        cmd_q.push_back(mk(1, 4'h6, 32'h0BAD_0BAD, 4'hF, 2'b00, 32'h0, 30, 30, 0, 0, 0, 0));
        begin
            int n = 0;
            @(negedge clk);
            while (!awvalid && n < 20) begin @(negedge clk); n++; end
            chk("rst_mid_awvalid_seen", awvalid, 1'b1);
        end
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
        chk("rst_mid_awvalid", awvalid, 1'b0);
        chk("rst_mid_wvalid", wvalid, 1'b0);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk("rst_mid_no_rsp", done_cnt, base);
        cmd_q.push_back(mk(0, 4'h1, 32'h0, 4'h0, 2'b00, 32'h7777_1234, 1, 0, 1, 0, 2, 1));
        wait_done(base + 1, 60);
        chk("r3_rdata", last_rsp_rdata, 32'h7777_1234);
        chk("r3_araddr", last_araddr, 32'h1);

        // randomized traffic
        base = done_cnt;
        for (int i = 0; i < 150; i++) begin
            cmd_q.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom),
                               2'($urandom_range(0, 3)), $urandom,
                               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
        end
        wait_done(base + 150, 150 * 40);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
